elastic_pipe_reg: RTL and testbench
===================================

Name: elastic_pipe_reg

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline with a per-stage valid bit and valid/ready backpressure.
- Bubbles collapse: an empty stage accepts data even while downstream is stalled.
- Used as the standard retiming and decoupling stage between streaming blocks in the sequential library.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 3, number of register stages (>=1); DEPTH=0 is a compile-time error.
- RESET_VAL, 0, WIDTH-bit value loaded into every data register on reset.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all stage valids.
- in_valid  input  1  upstream data valid.
- in_data  input  WIDTH  upstream data.
- in_ready  output  1  block can accept in_data this cycle.
- out_valid  output  1  valid bit of stage DEPTH-1.
- out_data  output  WIDTH  data of stage DEPTH-1.
- out_ready  input  1  downstream accepts out_data.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages; present only with ELASTIC_PIPE_OCC_EN.

Behaviour:
- Reset and clock: reset rst_n, asynchronous, active-low; clock clk.
- Reset state:
  - While rst_n=0, every valid[i]=0 and every data[i]=RESET_VAL.
  - Outputs: out_valid=0, out_data=RESET_VAL, occupancy=0.
  - in_ready=0 while rst_n=0; it is 1 from the first cycle after release.
  - Deassertion of rst_n is synchronised externally; no internal synchroniser.
- Ready chain (combinational): rdy[DEPTH]=out_ready; rdy[i] = !valid[i] || rdy[i+1]; in_ready = rdy[0] && !flush.
- Stage update on each posedge, with src = in_* for i=0 and stage i-1 otherwise:
  - When rdy[i]=1: valid[i] <= src_valid.
  - When rdy[i]=1 and src_valid=1: data[i] <= src_data.
  - When rdy[i]=1 and src_valid=0: data[i] holds, to avoid needless toggling.
  - When rdy[i]=0: stage holds both valid and data.
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Latency and throughput:
  - Empty pipe, out_ready=1: data accepted at edge N appears on out_data after edge N+DEPTH-1, so DEPTH cycles of latency.
  - Throughput is 1 word per cycle sustained.
- Stall: out_ready=0 with all stages valid gives in_ready=0 and all data held stable. No word is lost or duplicated.
- Bubble collapse: with out_ready=0 and a gap at stage k, stages below k still advance until the gap fills.
- Ordering: strict FIFO; no reordering.
- Flush:
  - flush=1 at an edge clears all valid[i]. Data registers hold their contents.
  - in_data is not accepted that cycle; in_ready=0 whenever flush=1.
  - An output transfer presented in the flush cycle completes normally, since the downstream sampled it.
  - Flush takes priority over any load.
- Protocol rules:
  - out_valid never depends combinationally on out_ready.
  - in_ready does depend combinationally on out_ready. This path depth is accepted and documented.
- Reset mid-stream: all in-flight words are discarded immediately (asynchronous); no partial state survives.

Optional Feature:
- Macro: ELASTIC_PIPE_OCC_EN.
- Defined:
  - occupancy port exists.
  - Registered count of valid stages, updated at the same edge as the valids.
  - Reads 0 after reset and after flush.
  - Saturates naturally at DEPTH; values above DEPTH are impossible and covered by an assertion.
- Undefined: the port and counter logic are absent.
- Data-path behaviour is identical either way.

Decomposition:
- Shared package seq_pkg:
  - function clog2_min1 for occupancy width.
  - DEPTH legality check constant/assertion macro.
- Natural sub-module: elastic_stage, holding one valid+data register with src/rdy interface. It is instantiated DEPTH times in a generate loop; the top holds the ready chain, flush and occupancy.

Test Plan:
- Reset: rst_n=0 for 3 cycles with random inputs -> out_valid=0, out_data=8'h00, in_ready=0; after release in_ready=1, occupancy=0.
- Streaming: WIDTH=8, DEPTH=3, out_ready=1, feed 8'h11,8'h22,8'h33,8'h44 on consecutive cycles -> 8'h11 appears on out_data 3 cycles after acceptance, then one word per cycle in order; occupancy reaches 3.
- Full stall: fill with 8'hA1..8'hA3, hold out_ready=0 -> in_ready=0, out_data=8'hA1 stable. Raise out_ready for 1 cycle -> exactly 8'hA1 consumed, in_ready=1 that cycle.
- Bubble collapse: load 8'h55 only, out_ready=0 -> 8'h55 reaches stage 2. Next two inputs 8'h66,8'h77 are accepted; then in_ready=0, occupancy=3.
- Flush: pipe holding 3 words plus in_valid=1 with flush=1 -> in_ready=0 that cycle. Next cycle out_valid=0, occupancy=0, and the next accepted word emerges first.
- Async reset mid-stream: drop rst_n between clock edges with 2 words in flight -> out_valid falls immediately without a clock edge; no stale word appears after release.

Source files
------------

// File: rtl/elastic_pipe_reg_pkg.sv
// Shared helpers for the elastic pipeline register: occupancy width and
// DEPTH legality.
package elastic_pipe_reg_pkg;

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = (n <= 2) ? 1 : $clog2(n);
    return w;
  endfunction

  // A pipeline needs at least one stage.
  function automatic bit depth_legal(input int unsigned depth);
    return (depth >= 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_reg_stage.sv
// One elastic stage: a valid bit plus a WIDTH-bit data register. The stage
// loads from its source whenever its ready (rdy) is high; the data register
// only toggles when a real word arrives. Flush clears the valid bit but
// leaves the data register untouched.
module elastic_pipe_reg_stage
  import elastic_pipe_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             rdy,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Valid bit: flush wins, otherwise follow the source when this stage moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (rdy) begin
      valid_q <= src_valid;
    end
  end

  // Data register: load only a real word, never during flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RESET_VAL;
    end else if (!flush && rdy && src_valid) begin
      data_q <= src_data;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// WIDTH-bit, DEPTH-stage elastic pipeline register with valid/ready
// backpressure and bubble collapse. The ready chain is combinational from
// out_ready back to in_ready; out_valid comes straight from a register.
// Optional occupancy counter enabled by defining ELASTIC_PIPE_OCC_EN.
module elastic_pipe_reg
  import elastic_pipe_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef ELASTIC_PIPE_OCC_EN
  ,
  output logic [clog2_min1(DEPTH+1)-1:0] occupancy
`endif
);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("elastic_pipe_reg: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];
  // rdy[i]: stage i may load this cycle; rdy[DEPTH] is the downstream ready.
  logic [DEPTH:0]   rdy;

  assign rdy[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    // An empty stage can always load, which is what collapses bubbles.
    assign rdy[i] = !valid[i] || rdy[i+1];

    if (i == 0) begin : g_src_in
      assign src_valid = in_valid;
      assign src_data  = in_data;
    end else begin : g_src_prev
      assign src_valid = valid[i-1];
      assign src_data  = data[i-1];
    end

    elastic_pipe_reg_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .rdy       (rdy[i]),
      .src_valid (src_valid),
      .src_data  (src_data),
      .valid     (valid[i]),
      .data      (data[i])
    );
  end

  // rst_n gating keeps in_ready low for the whole time reset is asserted.
  assign in_ready  = rdy[0] && !flush && rst_n;
  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];

`ifdef ELASTIC_PIPE_OCC_EN
  localparam int unsigned OccW = clog2_min1(DEPTH + 1);

  logic            in_xfer;
  logic            out_xfer;
  logic [OccW-1:0] occ_q;
  logic [OccW-1:0] occ_d;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Next count: flush empties the pipe, otherwise track net transfers.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_xfer && !out_xfer) begin
      occ_d = occ_q + OccW'(1);
    end else if (!in_xfer && out_xfer) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  // Count register, updated on the same edge as the stage valids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

  occ_bounded: assert property (@(posedge clk) disable iff (!rst_n) 32'(occ_q) <= DEPTH);
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed self-checking bench for elastic_pipe_reg (WIDTH=8, DEPTH=3).
// Accepted words go into a scoreboard queue; every output transfer pops and
// compares. Occupancy checks are active when ELASTIC_PIPE_OCC_EN is defined.
module tb_elastic_pipe_reg;
  import elastic_pipe_reg_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
`ifdef ELASTIC_PIPE_OCC_EN
  logic [clog2_min1(DEPTH+1)-1:0] occupancy;
`endif

  int tests = 0;
  int fails = 0;
  logic [WIDTH-1:0] sb [$];

  always #5 clk = ~clk;

  elastic_pipe_reg #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef ELASTIC_PIPE_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_occ(input string tag, input int unsigned exp);
`ifdef ELASTIC_PIPE_OCC_EN
    check(tag, 32'(occupancy), exp);
`endif
  endtask

  // Called at a falling edge: apply inputs, settle 1 time unit.
  task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic ordy,
                       input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  // Sample transfers just before the rising edge, then advance to the next
  // falling edge.
  task automatic tick();
    logic [WIDTH-1:0] exp;
    #2;
    if (out_valid && out_ready) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL sb_underflow observed=%0h expected=no_word", out_data);
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check("sb_out_data", 32'(out_data), 32'(exp));
      end
    end
    if (flush) sb.delete();
    if (in_valid && in_ready) sb.push_back(in_data);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      flush     = 1'($urandom_range(0, 1));
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 32'h00);
      check("rst_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("rel_in_ready", 32'(in_ready), 1);
    check("rel_out_valid", 32'(out_valid), 0);
    check_occ("rel_occ", 0);
    tick();

    // Streaming, latency DEPTH
    drive(1'b1, 8'h11, 1'b1, 1'b0); tick();
    check("lat_c0_valid", 32'(out_valid), 0);
    drive(1'b1, 8'h22, 1'b1, 1'b0); tick();
    check("lat_c1_valid", 32'(out_valid), 0);
    drive(1'b1, 8'h33, 1'b1, 1'b0); tick();
    check("lat_c2_valid", 32'(out_valid), 1);
    check("lat_c2_data", 32'(out_data), 32'h11);
    check_occ("stream_occ", 3);
    drive(1'b1, 8'h44, 1'b1, 1'b0); tick();
    check("stream_next_data", 32'(out_data), 32'h22);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
    end
    check("stream_drained", 32'(out_valid), 0);
    check("stream_sb_empty", sb.size(), 0);
    check_occ("stream_occ_end", 0);

    // Full stall
    drive(1'b1, 8'hA1, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hA2, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hA3, 1'b0, 1'b0); tick();
    check_occ("stall_occ", 3);
    drive(1'b1, 8'hA4, 1'b0, 1'b0);
    check("stall_in_ready", 32'(in_ready), 0);
    check("stall_out_data", 32'(out_data), 32'hA1);
    tick();
    check("stall_hold_data", 32'(out_data), 32'hA1);
    check("stall_hold_valid", 32'(out_valid), 1);
    drive(1'b1, 8'hA4, 1'b1, 1'b0);
    check("release_in_ready", 32'(in_ready), 1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("one_consumed", 32'(out_data), 32'hA2);
    check("refull_in_ready", 32'(in_ready), 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
    end
    check("stall_drained", 32'(out_valid), 0);
    check("stall_sb_empty", sb.size(), 0);

    // Bubble collapse
    drive(1'b1, 8'h55, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
    tick();
    check("bubble_head_valid", 32'(out_valid), 1);
    check("bubble_head_data", 32'(out_data), 32'h55);
    check_occ("bubble_occ1", 1);
    drive(1'b1, 8'h66, 1'b0, 1'b0);
    check("bubble_acc66", 32'(in_ready), 1);
    tick();
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    check("bubble_acc77", 32'(in_ready), 1);
    tick();
    drive(1'b1, 8'h88, 1'b0, 1'b0);
    check("bubble_full", 32'(in_ready), 0);
    check_occ("bubble_occ3", 3);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
    end
    check("bubble_drained", 32'(out_valid), 0);
    check("bubble_sb_empty", sb.size(), 0);

    // Flush with a word presented and an output transfer in the same cycle
    drive(1'b1, 8'hB1, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hB2, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hB3, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hB4, 1'b1, 1'b1);
    check("flush_in_ready", 32'(in_ready), 0);
    tick();
    check("flush_out_valid", 32'(out_valid), 0);
    check_occ("flush_occ", 0);
    drive(1'b1, 8'hC1, 1'b1, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
    tick();
    check("flush_first_valid", 32'(out_valid), 1);
    check("flush_first_data", 32'(out_data), 32'hC1);
    drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
    check("flush_drained", 32'(out_valid), 0);

    // Asynchronous reset mid-stream
    drive(1'b1, 8'hD1, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hD2, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
    check("pre_reset_valid", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 0);
    check("async_out_data", 32'(out_data), 32'h00);
    check("async_in_ready", 32'(in_ready), 0);
    check_occ("async_occ", 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      check("post_reset_empty", 32'(out_valid), 0);
      tick();
    end
    drive(1'b1, 8'hE1, 1'b1, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
    end
    check("final_sb_drained", sb.size(), 0);
    check("final_out_valid", 32'(out_valid), 0);
    check_occ("final_occ", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
